// File: rtl/pcileech_tx_pkg.sv
// Shared types and header layout for the FT601 transmit arbiter.
// Header word: magic | channel | sequence | payload length.
package pcileech_tx_pkg;

    localparam int LEN_W      = 16;
    localparam int SEQ_W      = 8;
    localparam int CH_FIELD_W = 4;

    localparam logic [3:0]  HDR_MAGIC = 4'hE;
    localparam logic [31:0] FILLER    = 32'hFFFF_FFFF;

    localparam int HDR_MAGIC_LSB = 28;
    localparam int HDR_CH_LSB    = 24;
    localparam int HDR_SEQ_LSB   = 16;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic logic [31:0] make_hdr(input logic [CH_FIELD_W-1:0] ch,
                                             input logic [SEQ_W-1:0]      seq,
                                             input logic [LEN_W-1:0]      len);
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 4]          = HDR_MAGIC;
        h[HDR_CH_LSB    +: CH_FIELD_W] = ch;
        h[HDR_SEQ_LSB   +: SEQ_W]      = seq;
        h[HDR_LEN_LSB   +: LEN_W]      = len;
        return h;
    endfunction

endpackage

// File: rtl/pcileech_tx_arbiter_if.sv
// Source-FIFO and TX-FIFO signals of the transmit arbiter, bundled per direction.
interface pcileech_tx_arbiter_if #(
    parameter int NUM_CH = 3
);
    import pcileech_tx_pkg::*;

    // src_req is a level held by the source until src_grant pulses for one cycle;
    // src_valid answers src_rd exactly one cycle later; out_wr is a plain write
    // strobe and out_afull leaves room for the two words already in flight.
    logic [NUM_CH-1:0]       src_req;
    logic [LEN_W*NUM_CH-1:0] src_len;
    logic [NUM_CH-1:0]       src_grant;
    logic [NUM_CH-1:0]       src_rd;
    logic [32*NUM_CH-1:0]    src_data;
    logic [NUM_CH-1:0]       src_valid;
    logic                    out_afull;
    logic                    out_wr;
    logic [31:0]             out_data;

    modport master (
        input  src_req, src_len, src_data, src_valid, out_afull,
        output src_grant, src_rd, out_wr, out_data
    );

    modport slave (
        output src_req, src_len, src_data, src_valid, out_afull,
        input  src_grant, src_rd, out_wr, out_data
    );

endinterface

// File: rtl/pcileech_rr_pick.sv
// Combinational round-robin picker: the first requester after 'last' wins,
// wrapping around, so the previous winner has the lowest priority.
module pcileech_rr_pick #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              found
);

    always_comb begin
        int              j;
        logic [CH_W-1:0] cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            j = int'(last) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            cand = CH_W'(j);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/pcileech_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the FT601 TX FIFO: one header
// word per granted packet, then the payload pulled from the source FIFO.
module pcileech_tx_arbiter
    import pcileech_tx_pkg::*;
#(
    parameter int NUM_CH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pcileech_tx_arbiter_if.master bus,
    output logic                  busy,
    output logic                  err_underrun,
    output state_t                state
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   last_ch;
    logic [CH_W-1:0]   pick_idx;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] pick_grant;
    logic              pick_found;

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  remaining;
    logic [SEQ_W-1:0]  seq;
    logic              word_due;

    logic [NUM_CH-1:0] grant_q;
    logic [NUM_CH-1:0] rd_q;
    logic              wr_q;
    logic [31:0]       data_q;
    logic              err_q;

    logic [LEN_W-1:0]  len_arr  [NUM_CH];
    logic [31:0]       data_arr [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign len_arr[i]  = bus.src_len[LEN_W*i +: LEN_W];
        assign data_arr[i] = bus.src_data[32*i +: 32];
    end

    pcileech_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .req   (bus.src_req),
        .last  (last_ch),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign bus.src_grant = grant_q;
    assign bus.src_rd    = rd_q;
    assign bus.out_wr    = wr_q;
    assign bus.out_data  = data_q;
    assign err_underrun  = err_q;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ch        <= '0;
            ch_mask   <= '0;
            last_ch   <= CH_W'(NUM_CH - 1);
            len_q     <= '0;
            remaining <= '0;
            seq       <= '0;
            word_due  <= 1'b0;
            grant_q   <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            grant_q  <= '0;
            wr_q     <= 1'b0;
            word_due <= |rd_q;

            // Every read owns one output slot; a missing word becomes filler so
            // the length announced in the header always matches the payload.
            if (word_due) begin
                wr_q <= 1'b1;
                if (bus.src_valid[ch]) begin
                    data_q <= data_arr[ch];
                end else begin
                    data_q <= FILLER;
                    err_q  <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    rd_q <= '0;
                    if (pick_found && !bus.out_afull) begin
                        ch      <= pick_idx;
                        ch_mask <= pick_grant;
                        len_q   <= len_arr[pick_idx];
                        grant_q <= pick_grant;
                        last_ch <= pick_idx;
                        state   <= ST_HDR;
                    end
                end

                // The first payload read goes out together with the header write.
                ST_HDR: begin
                    if (!bus.out_afull) begin
                        wr_q   <= 1'b1;
                        data_q <= make_hdr(CH_FIELD_W'(ch), seq, len_q);
                        seq    <= seq + SEQ_W'(1);
                        if (len_q == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            rd_q      <= ch_mask;
                            remaining <= len_q - LEN_W'(1);
                            state     <= (len_q == LEN_W'(1)) ? ST_DRAIN : ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (!bus.out_afull && remaining != '0) begin
                        rd_q      <= ch_mask;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        rd_q <= '0;
                    end
                end

                // The final word is forwarded on the same edge that leaves DRAIN.
                ST_DRAIN: begin
                    rd_q <= '0;
                    if (rd_q == '0) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_tx_arbiter.sv
// Bench for pcileech_tx_arbiter: table of single-packet vectors plus rotation,
// request-withdrawal and mid-packet reset sequences, checked by a word scoreboard.
module tb_pcileech_tx_arbiter;
    import pcileech_tx_pkg::*;

    localparam int NUM_CH = 3;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    logic   busy;
    logic   err_underrun;
    state_t state;

    pcileech_tx_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

    pcileech_tx_arbiter #(.NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .err_underrun (err_underrun),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        int          len;
        logic [31:0] start;
        int          under;
        bit          afr;
        logic [31:0] exp_hdr;
        int          exp_rds;
        bit          exp_err;
    } vec_t;

    vec_t        vt [6];
    logic [31:0] exp_q [$];
    logic [31:0] wr_log [$];
    int          checks = 0;
    int          errors = 0;
    int          seq_m;
    int          last_m;
    int          under_ch = -1;
    int          under_at = -1;
    bit          afull_rand = 1'b0;
    logic [2:0]  afull_hist = '0;
    logic [NUM_CH-1:0] rd_prev = '0;
    logic [15:0] len_v   [NUM_CH];
    logic [31:0] src_cnt [NUM_CH];
    logic [31:0] exp_cnt [NUM_CH];
    int          rd_count  [NUM_CH];
    int          rds_total [NUM_CH];
    int          grants    [NUM_CH];
    int          rearm     [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_CH-1:0] req, input int last);
        int c;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (last + k) % NUM_CH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One clock: monitor outputs at the negedge, then drive the sources.
    task automatic tick();
        logic [NUM_CH-1:0] req_s;
        int pred;
        req_s      = bus.src_req;
        afull_hist = {afull_hist[1:0], bus.out_afull};
        @(negedge clk);
        if (bus.out_wr) begin
            wr_log.push_back(bus.out_data);
            checks++;
            if (afull_hist == 3'b111) begin
                errors++;
                $display("FAIL afull_margin: write %h with out_afull high for 3 edges, expected no write", bus.out_data);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h expected no write", bus.out_data);
            end else begin
                chk("out_data", bus.out_data, exp_q.pop_front());
            end
        end
        if (bus.src_grant != '0) begin
            pred = rr_pick(req_s, last_m);
            chk("grant", 32'(bus.src_grant), (pred < 0) ? 32'd0 : (32'd1 << pred));
            if (pred >= 0) begin
                exp_q.push_back({4'hE, 4'(pred), 8'(seq_m), len_v[pred]});
                for (int k = 0; k < int'(len_v[pred]); k++) begin
                    exp_q.push_back((pred == under_ch && k == under_at) ? 32'hFFFF_FFFF
                                                                        : exp_cnt[pred] + 32'(k));
                end
                exp_cnt[pred] += 32'(len_v[pred]);
                seq_m          = (seq_m + 1) % 256;
                last_m         = pred;
                grants[pred]++;
                rd_count[pred] = 0;
                if (rearm[pred] > 0) rearm[pred]--;
                else bus.src_req[pred] = 1'b0;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            bus.src_valid[i]        = 1'b0;
            bus.src_data[32*i +: 32] = 32'h0BAD_0BAD;
            if (rd_prev[i]) begin
                if (!(i == under_ch && rd_count[i] == under_at)) begin
                    bus.src_valid[i]        = 1'b1;
                    bus.src_data[32*i +: 32] = src_cnt[i];
                end
                src_cnt[i]++;
                rd_count[i]++;
            end
            if (bus.src_rd[i]) rds_total[i]++;
        end
        rd_prev = bus.src_rd;
        if (afull_rand) bus.out_afull = ($urandom_range(0, 3) == 0);
    endtask

    task automatic arm(input int ch, input int len, input logic [31:0] start, input int re);
        len_v[ch]                 = 16'(len);
        bus.src_len[16*ch +: 16]  = 16'(len);
        src_cnt[ch]               = start;
        exp_cnt[ch]               = start;
        rearm[ch]                 = re;
        bus.src_req[ch]           = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() != 0 || busy || bus.src_req != '0) && n < budget);
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
        end
        repeat (3) tick();
    endtask

    task automatic reset_and_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_grant"}, 32'(bus.src_grant), 32'd0);
        chk({tag, "_rd"},    32'(bus.src_rd),    32'd0);
        chk({tag, "_wr"},    32'(bus.out_wr),    32'd0);
        chk({tag, "_data"},  bus.out_data,       32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_err"},   32'(err_underrun),  32'd0);
        chk({tag, "_state"}, 32'(state),         32'(ST_IDLE));
        exp_q.delete();
        bus.src_req   = '0;
        bus.src_valid = '0;
        bus.out_afull = 1'b0;
        rd_prev       = '0;
        afull_hist    = '0;
        afull_rand    = 1'b0;
        under_ch      = -1;
        seq_m         = 0;
        last_m        = NUM_CH - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base;
        int rds0;
        base       = wr_log.size();
        rds0       = rds_total[v.ch];
        under_ch   = (v.under >= 0) ? v.ch : -1;
        under_at   = v.under;
        afull_rand = v.afr;
        arm(v.ch, v.len, v.start, 0);
        wait_idle(3000, $sformatf("vec%0d", idx));
        afull_rand    = 1'b0;
        bus.out_afull = 1'b0;
        under_ch      = -1;
        chk($sformatf("vec%0d_hdr", idx), (wr_log.size() > base) ? wr_log[base] : 32'd0, v.exp_hdr);
        chk($sformatf("vec%0d_writes", idx), 32'(wr_log.size() - base), 32'(v.len + 1));
        chk($sformatf("vec%0d_rds", idx), 32'(rds_total[v.ch] - rds0), 32'(v.exp_rds));
        chk($sformatf("vec%0d_err", idx), 32'(err_underrun), 32'(v.exp_err));
        chk($sformatf("vec%0d_busy", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int g1;
        vt[0] = '{1,  4, 32'h0000_0001, -1, 1'b0, 32'hE100_0004,  4, 1'b0};
        vt[1] = '{2,  0, 32'h0000_0000, -1, 1'b0, 32'hE201_0000,  0, 1'b0};
        vt[2] = '{0, 64, 32'h0000_0100, -1, 1'b1, 32'hE002_0040, 64, 1'b0};
        vt[3] = '{1,  5, 32'h0000_0200,  2, 1'b0, 32'hE103_0005,  5, 1'b1};
        vt[4] = '{2,  1, 32'h0000_0300, -1, 1'b0, 32'hE204_0001,  1, 1'b1};
        vt[5] = '{0,  3, 32'h0000_0A00, -1, 1'b0, 32'hE005_0003,  3, 1'b1};

        bus.src_req   = '0;
        bus.src_len   = '0;
        bus.src_data  = '0;
        bus.src_valid = '0;
        bus.out_afull = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            len_v[i] = '0; src_cnt[i] = '0; exp_cnt[i] = '0;
            rd_count[i] = 0; rds_total[i] = 0; grants[i] = 0; rearm[i] = 0;
        end

        #2;
        reset_and_check("por");
        tick();
        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Sticky underrun flag must be cleared by reset; rotation restarts at ch0.
        reset_and_check("pre_rot");
        base = wr_log.size();
        arm(0, 2, 32'h0000_1000, 9);
        arm(1, 2, 32'h0000_2000, 9);
        arm(2, 2, 32'h0000_3000, 9);
        for (int i = 0; i < NUM_CH; i++) grants[i] = 0;
        wait_idle(3000, "rotation");
        chk("rot_hdr0", (wr_log.size() > base + 0) ? wr_log[base + 0] : 32'd0, 32'hE000_0002);
        chk("rot_hdr1", (wr_log.size() > base + 3) ? wr_log[base + 3] : 32'd0, 32'hE101_0002);
        chk("rot_hdr2", (wr_log.size() > base + 6) ? wr_log[base + 6] : 32'd0, 32'hE202_0002);
        chk("rot_hdr3", (wr_log.size() > base + 9) ? wr_log[base + 9] : 32'd0, 32'hE003_0002);
        chk("rot_writes", 32'(wr_log.size() - base), 32'd90);
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("rot_grants%0d", i), 32'(grants[i]), 32'd10);

        // A request withdrawn before the arbiter returns to IDLE gets no grant.
        base = wr_log.size();
        g1   = grants[1];
        arm(0, 8, 32'h0000_4000, 0);
        repeat (3) tick();
        len_v[1]               = 16'd3;
        bus.src_len[16 +: 16]  = 16'd3;
        bus.src_req[1]         = 1'b1;
        repeat (2) tick();
        bus.src_req[1] = 1'b0;
        wait_idle(500, "withdraw");
        chk("withdraw_grants1", 32'(grants[1] - g1), 32'd0);
        chk("withdraw_hdr", (wr_log.size() > base) ? wr_log[base] : 32'd0, 32'hE01E_0008);
        chk("withdraw_writes", 32'(wr_log.size() - base), 32'd9);

        // Reset in the middle of a payload abandons it and restarts seq/rotation.
        arm(0, 20, 32'h0000_5000, 0);
        repeat (6) tick();
        chk("mid_pre_state", 32'(state), 32'(ST_DATA));
        #2;
        reset_and_check("mid");
        base = wr_log.size();
        arm(1, 1, 32'h0000_6000, 0);
        arm(0, 1, 32'h0000_7000, 0);
        wait_idle(500, "post_reset");
        chk("post_hdr0", (wr_log.size() > base) ? wr_log[base] : 32'd0, 32'hE000_0001);
        chk("post_hdr1", (wr_log.size() > base + 2) ? wr_log[base + 2] : 32'd0, 32'hE101_0001);
        chk("post_writes", 32'(wr_log.size() - base), 32'd4);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
